miniproject_mem_arbiter: RTL and testbench
==========================================

Name: miniproject_mem_arbiter

Overview:
- Two-requester arbiter in front of the single-port 32-bit on-chip memory (51200 words, 16-bit word address, 4 byte enables).
- Read latency of the memory is 1 cycle: address is registered, q is unregistered.
- Presents two Avalon-MM-style slave ports (m0 = CPU data master, m1 = LCD/motor DMA reader) and drives one memory port.
- Grants are round-robin per transaction; read responses are routed back to the issuing port; out-of-range accesses are trapped.

Parameters:
- ADDR_W, 16, word address width on all ports
- DEPTH, 51200, number of valid words; address >= DEPTH is out of range
- ERR_DATA, 32'hDEAD_BEEF, read data returned for out-of-range reads

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- mX_address  in  ADDR_W  word address (X = 0, 1; same set per port)
- mX_byteenable  in  4  byte lanes for writes
- mX_read  in  1  read request
- mX_write  in  1  write request
- mX_writedata  in  32  write data
- mX_waitrequest  out  1  high = command not accepted this cycle
- mX_readdata  out  32  read response data
- mX_readdatavalid  out  1  one-cycle read response strobe
- mem_address  out  ADDR_W  to memory
- mem_byteenable  out  4  to memory
- mem_chipselect  out  1  to memory
- mem_write  out  1  to memory
- mem_writedata  out  32  to memory
- mem_clken  out  1  memory clock enable; = ~reset
- mem_readdata  in  32  memory q, valid 1 cycle after read issue
- err_sticky  out  1  set on any out-of-range access
- err_clear  in  1  clears err_sticky
- err_addr  out  ADDR_W  address of the first out-of-range access since clear

Behaviour:
- Command request: reqX = mX_read | mX_write. If both are high on one port, it is treated as a write.
- Grant is combinational each cycle, with no lock across cycles:
  - only one port requesting: that port wins;
  - both requesting: the port != last_grant wins.
- last_grant register: updated to the winner on every accepted command; reset value 1, so m0 wins the first contention.
- Waitrequest: mX_waitrequest = reqX & ~grantX. An idle port sees 0. Exactly one command is accepted per cycle.
- Memory drive:
  - winner's address, byteenable and writedata are muxed to mem_*;
  - mem_chipselect = accepted & in_range; mem_write = chipselect & write;
  - with no winner, mem_chipselect = 0 and the other mem_* outputs hold the m0 values (don't-care).
- in_range = address < DEPTH. An out-of-range write never reaches the memory.
- Read response pipeline (one stage, registers rsp_valid, rsp_owner, rsp_err):
  - loaded on an accepted read; rsp_valid = 0 otherwise;
  - cycle N+1 after acceptance: mY_readdatavalid = 1 for Y = rsp_owner;
  - mY_readdata = rsp_err ? ERR_DATA : mem_readdata;
  - the non-owner port's readdatavalid = 0 and its readdata = 0.
- Back-to-back reads (same or alternating ports) issue every cycle with no bubble. Read latency is exactly 1 from acceptance. Writes produce no response.
- Error capture:
  - first out-of-range accepted command while err_sticky = 0 sets err_sticky and loads err_addr;
  - later errors do not overwrite err_addr;
  - err_clear = 1 clears err_sticky next cycle;
  - an error and err_clear in the same cycle: error wins (sticky stays 1, err_addr reloaded).
- Reset:
  - all waitrequest = 0, readdatavalid = 0, readdata = 0;
  - rsp_valid = 0, so an in-flight response is squashed;
  - err_sticky = 0, err_addr = 0, last_grant = 1, mem_chipselect = 0;
  - requests presented during reset are not accepted (waitrequest = reqX).
- Masters must hold a command stable while waitrequest = 1; the arbiter does not check this.

Test Plan:
- m0 writes 0x1234_5678 to addr 0x0010, byteenable 4'hF; then m1 reads 0x0010 -> m1_readdatavalid high exactly 1 cycle after acceptance, m1_readdata = 0x1234_5678, m0_readdatavalid stays 0.
- Both ports assert reads continuously from reset (m0 addr 1, m1 addr 2) -> grants alternate m0, m1, m0, ...; each port sees waitrequest high every other cycle; responses arrive in order with correct owner; no idle memory cycle.
- Byte-enable write of 0xAABB_CCDD with byteenable 4'b0101 over 0x0000_0000, then read back -> 0x00BB_00DD.
- m0 reads 51200 (0xC800) -> mem_chipselect stays 0; m0_readdata = 0xDEAD_BEEF; err_sticky = 1, err_addr = 0xC800. A second bad write to 0xFFFF leaves err_addr unchanged. Pulsing err_clear then clears err_sticky.
- Reset asserted the cycle after an accepted read -> no readdatavalid on either port; after reset release, m0 wins first contention.
- m1 asserts read and write together to addr 5 with data 0x55 -> treated as a write, memory word 5 becomes 0x55, no readdatavalid.

Source files
------------

// File: rtl/miniproject_mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port 32-bit memory.
// Routes 1-cycle read responses back to the issuer and traps out-of-range accesses.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   m0_* / m1_*         Avalon-MM style slave ports (m0 = CPU, m1 = DMA)
//                       address, byteenable, read, write, writedata in;
//                       waitrequest, readdata, readdatavalid out
//   mem_*               single memory port; mem_readdata is q, valid
//                       one cycle after the read was issued
//   err_sticky/err_addr first out-of-range access since err_clear
module miniproject_mem_arbiter #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DEPTH    = 51200,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic [3:0]        m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [31:0]       m0_writedata,
    output logic              m0_waitrequest,
    output logic [31:0]       m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic [3:0]        m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [31:0]       m1_writedata,
    output logic              m1_waitrequest,
    output logic [31:0]       m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              mem_clken,
    input  logic [31:0]       mem_readdata,

    output logic              err_sticky,
    input  logic              err_clear,
    output logic [ADDR_W-1:0] err_addr
);

    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

    logic              req0;
    logic              req1;
    logic              gnt0;
    logic              gnt1;
    logic              accepted;

    logic [ADDR_W-1:0] sel_addr;
    logic [3:0]        sel_be;
    logic [31:0]       sel_wdata;
    logic              sel_write;
    logic              in_range;
    logic              rd_accept;
    logic              err_hit;

    logic              last_grant_q;
    logic              last_grant_d;
    logic              rsp_valid_q;
    logic              rsp_valid_d;
    logic              rsp_owner_q;
    logic              rsp_owner_d;
    logic              rsp_err_q;
    logic              rsp_err_d;
    logic              err_sticky_q;
    logic              err_sticky_d;
    logic [ADDR_W-1:0] err_addr_q;
    logic [ADDR_W-1:0] err_addr_d;

    logic [31:0]       rsp_data;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // Grant is recomputed every cycle; on contention the port that did
    // not win last time goes first. Nothing is accepted during reset.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (req0 && req1) begin
                gnt0 = last_grant_q;
                gnt1 = ~last_grant_q;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    assign accepted = gnt0 | gnt1;

    assign m0_waitrequest = req0 & ~gnt0;
    assign m1_waitrequest = req1 & ~gnt1;

    // With no winner the m0 command is presented; chipselect stays low.
    always_comb begin
        sel_addr  = m0_address;
        sel_be    = m0_byteenable;
        sel_wdata = m0_writedata;
        sel_write = m0_write;
        if (gnt1) begin
            sel_addr  = m1_address;
            sel_be    = m1_byteenable;
            sel_wdata = m1_writedata;
            sel_write = m1_write;
        end
    end

    assign in_range = ({1'b0, sel_addr} < DEPTH_L);

    // read+write together is a write, so only pure reads get a response.
    assign rd_accept = accepted & ~sel_write;
    assign err_hit   = accepted & ~in_range;

    assign mem_address    = sel_addr;
    assign mem_byteenable = sel_be;
    assign mem_writedata  = sel_wdata;
    assign mem_chipselect = accepted & in_range;
    assign mem_write      = mem_chipselect & sel_write;
    assign mem_clken      = ~reset;

    always_comb begin
        last_grant_d = last_grant_q;
        if (accepted) begin
            last_grant_d = gnt1;
        end
    end

    always_comb begin
        rsp_valid_d = rd_accept;
        rsp_owner_d = gnt1;
        rsp_err_d   = ~in_range;
    end

    // A new error reloads the address when the flag is clear or being
    // cleared in the same cycle; otherwise the first address is kept.
    always_comb begin
        err_sticky_d = err_sticky_q;
        err_addr_d   = err_addr_q;
        if (err_hit && (!err_sticky_q || err_clear)) begin
            err_sticky_d = 1'b1;
            err_addr_d   = sel_addr;
        end else if (err_clear) begin
            err_sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_owner_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            err_sticky_q <= 1'b0;
            err_addr_q   <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_owner_q  <= rsp_owner_d;
            rsp_err_q    <= rsp_err_d;
            err_sticky_q <= err_sticky_d;
            err_addr_q   <= err_addr_d;
        end
    end

    // Gating with reset squashes a response that was in flight when
    // reset arrived, before the register itself has cleared.
    assign rsp_data = rsp_err_q ? ERR_DATA : mem_readdata;

    assign m0_readdatavalid = ~reset & rsp_valid_q & ~rsp_owner_q;
    assign m1_readdatavalid = ~reset & rsp_valid_q & rsp_owner_q;
    assign m0_readdata      = m0_readdatavalid ? rsp_data : 32'h0;
    assign m1_readdata      = m1_readdatavalid ? rsp_data : 32'h0;

    assign err_sticky = err_sticky_q;
    assign err_addr   = err_addr_q;

endmodule

// File: tb/tb_miniproject_mem_arbiter.sv
// Directed bench for miniproject_mem_arbiter with a behavioural
// 1-cycle-latency byte-enabled memory model.
module tb_miniproject_mem_arbiter;

    logic        clk;
    logic        reset;
    logic [15:0] m0_address;
    logic [3:0]  m0_byteenable;
    logic        m0_read;
    logic        m0_write;
    logic [31:0] m0_writedata;
    logic        m0_waitrequest;
    logic [31:0] m0_readdata;
    logic        m0_readdatavalid;
    logic [15:0] m1_address;
    logic [3:0]  m1_byteenable;
    logic        m1_read;
    logic        m1_write;
    logic [31:0] m1_writedata;
    logic        m1_waitrequest;
    logic [31:0] m1_readdata;
    logic        m1_readdatavalid;
    logic [15:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic        mem_clken;
    logic [31:0] mem_readdata;
    logic        err_sticky;
    logic        err_clear;
    logic [15:0] err_addr;

    int n_chk;
    int n_fail;

    miniproject_mem_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .m0_address       (m0_address),
        .m0_byteenable    (m0_byteenable),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writedata     (m0_writedata),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_byteenable    (m1_byteenable),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .mem_address      (mem_address),
        .mem_byteenable   (mem_byteenable),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_writedata    (mem_writedata),
        .mem_clken        (mem_clken),
        .mem_readdata     (mem_readdata),
        .err_sticky       (err_sticky),
        .err_clear        (err_clear),
        .err_addr         (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: registered address, unregistered q.
    logic [31:0] mem [0:51199];
    logic [15:0] raddr;

    initial begin
        raddr = 16'h0;
        for (int i = 0; i < 51200; i++) mem[i] = 32'h0;
    end

    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_byteenable[b])
                        mem[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
                end
            end
            raddr <= mem_address;
        end
    end

    assign mem_readdata = mem[raddr];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_read = 0; m0_write = 0;
        m1_read = 0; m1_write = 0;
        err_clear = 0;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        m0_address = 0; m0_byteenable = 4'hF; m0_writedata = 0;
        m1_address = 0; m1_byteenable = 4'hF; m1_writedata = 0;
        idle();
        reset = 1;

        // Reset state, request held during reset is not accepted
        cyc();
        m0_read = 1; m0_address = 16'h1;
        #1;
        chk("rst_wait0", {31'b0, m0_waitrequest}, 1);
        chk("rst_wait1", {31'b0, m1_waitrequest}, 0);
        chk("rst_cs", {31'b0, mem_chipselect}, 0);
        chk("rst_clken", {31'b0, mem_clken}, 0);
        chk("rst_rdv0", {31'b0, m0_readdatavalid}, 0);
        chk("rst_rdata0", m0_readdata, 0);
        chk("rst_sticky", {31'b0, err_sticky}, 0);
        chk("rst_eaddr", {16'b0, err_addr}, 0);
        cyc();
        reset = 0;
        idle();
        #1;
        chk("idle_cs", {31'b0, mem_chipselect}, 0);
        chk("idle_clken", {31'b0, mem_clken}, 1);

        // m0 write, then m1 read back
        m0_write = 1; m0_address = 16'h0010; m0_writedata = 32'h1234_5678;
        #1;
        chk("w_wait0", {31'b0, m0_waitrequest}, 0);
        chk("w_cs", {31'b0, mem_chipselect}, 1);
        chk("w_we", {31'b0, mem_write}, 1);
        chk("w_addr", {16'b0, mem_address}, 32'h10);
        cyc();
        idle();
        m1_read = 1; m1_address = 16'h0010;
        #1;
        chk("r_wait1", {31'b0, m1_waitrequest}, 0);
        chk("w_nodv0", {31'b0, m0_readdatavalid}, 0);
        chk("r_early1", {31'b0, m1_readdatavalid}, 0);
        cyc();
        idle();
        #1;
        chk("r_dv1", {31'b0, m1_readdatavalid}, 1);
        chk("r_data1", m1_readdata, 32'h1234_5678);
        chk("r_dv0", {31'b0, m0_readdatavalid}, 0);
        chk("r_data0", m0_readdata, 0);
        cyc();
        #1;
        chk("r_late1", {31'b0, m1_readdatavalid}, 0);

        // Seed words 1 and 2
        m0_write = 1; m0_address = 16'h1; m0_writedata = 32'h1111_1111;
        cyc();
        m0_address = 16'h2; m0_writedata = 32'h2222_2222;
        cyc();
        idle();

        // Reset right after an accepted read squashes the response
        m0_read = 1; m0_address = 16'h1;
        cyc();
        idle();
        reset = 1;
        #1;
        chk("sq_dv0", {31'b0, m0_readdatavalid}, 0);
        chk("sq_dv1", {31'b0, m1_readdatavalid}, 0);
        chk("sq_data0", m0_readdata, 0);
        cyc();
        reset = 0;

        // Continuous contention: m0 first, then alternating
        m0_read = 1; m0_address = 16'h1;
        m1_read = 1; m1_address = 16'h2;
        #1;
        chk("c0_wait0", {31'b0, m0_waitrequest}, 0);
        chk("c0_wait1", {31'b0, m1_waitrequest}, 1);
        chk("c0_addr", {16'b0, mem_address}, 32'h1);
        chk("c0_dv0", {31'b0, m0_readdatavalid}, 0);
        cyc();
        #1;
        chk("c1_wait0", {31'b0, m0_waitrequest}, 1);
        chk("c1_wait1", {31'b0, m1_waitrequest}, 0);
        chk("c1_cs", {31'b0, mem_chipselect}, 1);
        chk("c1_addr", {16'b0, mem_address}, 32'h2);
        chk("c1_dv0", {31'b0, m0_readdatavalid}, 1);
        chk("c1_data0", m0_readdata, 32'h1111_1111);
        chk("c1_dv1", {31'b0, m1_readdatavalid}, 0);
        cyc();
        #1;
        chk("c2_wait0", {31'b0, m0_waitrequest}, 0);
        chk("c2_wait1", {31'b0, m1_waitrequest}, 1);
        chk("c2_cs", {31'b0, mem_chipselect}, 1);
        chk("c2_dv1", {31'b0, m1_readdatavalid}, 1);
        chk("c2_data1", m1_readdata, 32'h2222_2222);
        chk("c2_dv0", {31'b0, m0_readdatavalid}, 0);
        cyc();
        idle();
        #1;
        chk("c3_dv0", {31'b0, m0_readdatavalid}, 1);
        chk("c3_data0", m0_readdata, 32'h1111_1111);
        cyc();
        #1;
        chk("c4_dv0", {31'b0, m0_readdatavalid}, 0);
        chk("c4_dv1", {31'b0, m1_readdatavalid}, 0);

        // Partial byte-enable write
        m0_write = 1; m0_address = 16'h0020;
        m0_writedata = 32'hAABB_CCDD; m0_byteenable = 4'b0101;
        #1;
        chk("be_lanes", {28'b0, mem_byteenable}, 32'h5);
        cyc();
        idle();
        m0_byteenable = 4'hF;
        m0_read = 1;
        cyc();
        idle();
        #1;
        chk("be_data", m0_readdata, 32'h00BB_00DD);

        // Out-of-range read, sticky error, second bad write, clear
        cyc();
        m0_read = 1; m0_address = 16'hC800;
        #1;
        chk("oor_cs", {31'b0, mem_chipselect}, 0);
        chk("oor_wait0", {31'b0, m0_waitrequest}, 0);
        cyc();
        idle();
        #1;
        chk("oor_dv0", {31'b0, m0_readdatavalid}, 1);
        chk("oor_data0", m0_readdata, 32'hDEAD_BEEF);
        chk("oor_sticky", {31'b0, err_sticky}, 1);
        chk("oor_eaddr", {16'b0, err_addr}, 32'hC800);
        m0_write = 1; m0_address = 16'hFFFF; m0_writedata = 32'h0BAD;
        #1;
        chk("oor_w_cs", {31'b0, mem_chipselect}, 0);
        chk("oor_w_we", {31'b0, mem_write}, 0);
        cyc();
        idle();
        #1;
        chk("oor2_eaddr", {16'b0, err_addr}, 32'hC800);
        chk("oor2_dv0", {31'b0, m0_readdatavalid}, 0);
        err_clear = 1;
        cyc();
        idle();
        #1;
        chk("clr_sticky", {31'b0, err_sticky}, 0);
        chk("clr_eaddr", {16'b0, err_addr}, 32'hC800);

        // Error in the same cycle as clear: error wins
        m1_write = 1; m1_address = 16'hC900; m1_writedata = 32'h1;
        cyc();
        idle();
        #1;
        chk("e1_sticky", {31'b0, err_sticky}, 1);
        chk("e1_eaddr", {16'b0, err_addr}, 32'hC900);
        m1_write = 1; m1_address = 16'hD000;
        err_clear = 1;
        cyc();
        idle();
        #1;
        chk("ec_sticky", {31'b0, err_sticky}, 1);
        chk("ec_eaddr", {16'b0, err_addr}, 32'hD000);

        // m1 read+write together behaves as a write
        m1_read = 1; m1_write = 1; m1_address = 16'h5;
        m1_writedata = 32'h55; m1_byteenable = 4'hF;
        #1;
        chk("rw_cs", {31'b0, mem_chipselect}, 1);
        chk("rw_we", {31'b0, mem_write}, 1);
        chk("rw_wdata", mem_writedata, 32'h55);
        cyc();
        idle();
        #1;
        chk("rw_dv1", {31'b0, m1_readdatavalid}, 0);
        chk("rw_dv0", {31'b0, m0_readdatavalid}, 0);
        m1_read = 1;
        cyc();
        idle();
        #1;
        chk("rw_rd_dv1", {31'b0, m1_readdatavalid}, 1);
        chk("rw_rd_data1", m1_readdata, 32'h55);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
